psum_accum: RTL and testbench

Downstream neighbour of the `mac` column: collects the per-column partial sums leaving the bottom row of the array and accumulates them over a programmable number of input-channel tiles. Applies an optional ReLU to each finished sum and hands it to the output SRAM writer through a valid/ready interface. All `col` lanes share one control path and are processed in lockstep.

---
 rtl/psum_accum_pkg.sv | 23 ++
 rtl/psum_accum_sat_add.sv | 36 +++
 rtl/psum_accum.sv | 129 ++++++++++++
 tb/tb_psum_accum.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_pkg.sv
// Shared types and saturation bounds for the partial-sum accumulator.
package psum_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int PSUM_BW = 16;

  function automatic int psum_max(input int bw);
    return (32'sd1 <<< (bw - 1)) - 32'sd1;
  endfunction

  function automatic int psum_min(input int bw);
    return -(32'sd1 <<< (bw - 1));
  endfunction

  localparam int PSUM_MAX = psum_max(PSUM_BW);
  localparam int PSUM_MIN = psum_min(PSUM_BW);

endpackage

// File: rtl/psum_accum_sat_add.sv
// Single-lane saturating adder; o_emit is the clamped sum with optional ReLU.
module psum_sat_add
  import psum_accum_pkg::*;
#(
  parameter int bw = PSUM_BW
) (
  input  logic signed [bw-1:0] i_acc,
  input  logic signed [bw-1:0] i_din,
  input  logic                 i_relu,
  output logic signed [bw-1:0] o_sum,
  output logic signed [bw-1:0] o_emit
);

  localparam logic signed [bw:0] L_HI = (bw+1)'(psum_max(bw));
  localparam logic signed [bw:0] L_LO = (bw+1)'(psum_min(bw));

  logic signed [bw:0] w_wide;

  // one extra bit of headroom so the clamp decision is exact
  always_comb begin
    w_wide = (bw+1)'(i_acc) + (bw+1)'(i_din);
    if (w_wide > L_HI) begin
      o_sum = L_HI[bw-1:0];
    end else if (w_wide < L_LO) begin
      o_sum = L_LO[bw-1:0];
    end else begin
      o_sum = w_wide[bw-1:0];
    end
    if (i_relu && o_sum[bw-1]) begin
      o_emit = {bw{1'b0}};
    end else begin
      o_emit = o_sum;
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Accumulates column partial sums over cfg_len beats and emits cfg_num vectors
// per job through a valid/ready output; all lanes share one FSM.
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int cnt_bw  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [cnt_bw-1:0]        cfg_len,
  input  logic [cnt_bw-1:0]        cfg_num,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*psum_bw-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   out_data,
  output logic                     busy,
  output logic                     done
);

  localparam logic [cnt_bw-1:0] L_ZERO = {cnt_bw{1'b0}};
  localparam logic [cnt_bw-1:0] L_ONE  = cnt_bw'(1);

  state_t                           r_state, w_next;
  logic [cnt_bw-1:0]                r_len, r_num, r_beat, r_vec;
  logic                             r_relu, r_done;
  logic [col-1:0][psum_bw-1:0]      r_acc, r_out, w_sum, w_emit;
  logic                             w_take, w_last_beat, w_pop, w_job_end;

  assign w_take      = in_valid && (r_state == ST_ACCUM);
  assign w_last_beat = w_take && (r_beat == r_len - L_ONE);
  assign w_pop       = out_ready && (r_state == ST_DRAIN);
  assign w_job_end   = w_pop && (r_vec + L_ONE == r_num);

  genvar g;
  for (g = 0; g < col; g++) begin : g_lane
    psum_sat_add #(.bw(psum_bw)) u_lane (
      .i_acc  (r_acc[g]),
      .i_din  (in_data[g*psum_bw +: psum_bw]),
      .i_relu (r_relu),
      .o_sum  (w_sum[g]),
      .o_emit (w_emit[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = start ? ST_ACCUM : ST_IDLE;
      ST_ACCUM: w_next = w_last_beat ? ST_DRAIN : ST_ACCUM;
      ST_DRAIN: begin
        if (w_pop) begin
          w_next = w_job_end ? ST_IDLE : ST_ACCUM;
        end else begin
          w_next = ST_DRAIN;
        end
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_ACCUM);
    out_valid = (r_state == ST_DRAIN);
    busy      = (r_state != ST_IDLE);
    out_data  = r_out;
    done      = r_done;
  end

  // zero length/count configurations are stored as 1 so the compares stay simple
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len  <= L_ZERO;
      r_num  <= L_ZERO;
      r_relu <= 1'b0;
      r_beat <= L_ZERO;
      r_vec  <= L_ZERO;
      r_acc  <= '{default: {psum_bw{1'b0}}};
      r_out  <= '{default: {psum_bw{1'b0}}};
      r_done <= 1'b0;
    end else begin
      r_done <= w_job_end;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len  <= (cfg_len == L_ZERO) ? L_ONE : cfg_len;
            r_num  <= (cfg_num == L_ZERO) ? L_ONE : cfg_num;
            r_relu <= cfg_relu;
            r_beat <= L_ZERO;
            r_vec  <= L_ZERO;
            r_acc  <= '{default: {psum_bw{1'b0}}};
          end
        end
        ST_ACCUM: begin
          if (w_last_beat) begin
            r_out  <= w_emit;
            r_acc  <= '{default: {psum_bw{1'b0}}};
            r_beat <= L_ZERO;
          end else if (w_take) begin
            r_acc  <= w_sum;
            r_beat <= r_beat + L_ONE;
          end
        end
        ST_DRAIN: begin
          if (w_pop) begin
            r_vec <= r_vec + L_ONE;
          end
        end
        default: begin
          r_beat <= L_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// Scoreboard bench for psum_accum: a reference model queues expected vectors,
// an independent monitor pops and compares them on every output handshake.
module tb_psum_accum;
  import psum_accum_pkg::*;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int CB  = 6;
  localparam int W   = COL * BW;

  logic          clk = 1'b0;
  logic          reset, start, cfg_relu, in_valid, in_ready;
  logic          out_valid, out_ready, busy, done;
  logic [CB-1:0] cfg_len, cfg_num;
  logic [W-1:0]  in_data, out_data;

  always #5 clk = ~clk;

  psum_accum #(.col(COL), .psum_bw(BW), .cnt_bw(CB)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_num(cfg_num),
    .cfg_relu(cfg_relu), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [W-1:0] d;
    bit           last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] beat_q[$];
  int           errors = 0;
  int           checks = 0;
  bit           rand_ready = 1'b0;
  int           stall_ord = -1;
  int           stall_left = 0;
  int           vec_ord = 0;
  bit           prev_ov = 1'b0;
  bit           done_due = 1'b0;
  bit           held_valid = 1'b0;
  logic [W-1:0] held_data;
  exp_t         mon_e;

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] all_lanes(input int v);
    logic [W-1:0] r;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = v[BW-1:0];
    return r;
  endfunction

  // Reference: plain integer sums with a clamp after every beat.
  task automatic model_job(input int len, input int num, input bit relu);
    int L, N, s, x;
    logic [W-1:0] bv, res;
    logic signed [BW-1:0] lv;
    exp_t e;
    L = (len == 0) ? 1 : len;
    N = (num == 0) ? 1 : num;
    for (int v = 0; v < N; v++) begin
      for (int k = 0; k < COL; k++) begin
        s = 0;
        for (int b = 0; b < L; b++) begin
          bv = beat_q[v*L + b];
          lv = bv[k*BW +: BW];
          x  = int'(lv);
          s  = s + x;
          if (s > PSUM_MAX) s = PSUM_MAX;
          if (s < PSUM_MIN) s = PSUM_MIN;
        end
        if (relu && s < 0) s = 0;
        res[k*BW +: BW] = s[BW-1:0];
      end
      e.d = res;
      e.last = (v == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int len, input int num, input bit relu);
    @(posedge clk); #1;
    start = 1'b1; cfg_len = len[CB-1:0]; cfg_num = num[CB-1:0]; cfg_relu = relu;
    @(posedge clk); #1;
    start = 1'b0;
    check_bit("busy_after_start", busy, 1'b1);
    check_bit("in_ready_after_start", in_ready, 1'b1);
  endtask

  task automatic send_beat(input logic [W-1:0] d, input bit gaps);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 300) begin
        errors++; checks++;
        $display("FAIL beat_timeout in_ready=%b required=1", in_ready);
        break;
      end
    end
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL job_timeout busy=%b pending=%0d required busy=0 pending=0", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_job(input int len, input int num, input bit relu, input bit gaps);
    model_job(len, num, relu);
    do_start(len, num, relu);
    foreach (beat_q[i]) send_beat(beat_q[i], gaps);
    in_valid = 1'b0;
    beat_q.delete();
    wait_idle();
  endtask

  // out_ready policy: optional fixed 5-cycle stall on one chosen vector
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset !== 1'b1) begin
        stall_left = 0; prev_ov = 1'b0; out_ready = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          vec_ord++;
          if (vec_ord == stall_ord) stall_left = 5;
        end
        prev_ov = out_valid;
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
      end
    end
  end

  // Monitor: judges the handshake that the next rising edge will complete.
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        done_due = 1'b0; held_valid = 1'b0;
      end else begin
        check_bit("done", done, done_due);
        done_due = 1'b0;
        if (out_valid) begin
          check_bit("in_ready_in_drain", in_ready, 1'b0);
          if (held_valid) check_vec("out_data_stable", out_data, held_data);
          if (out_ready) begin
            held_valid = 1'b0;
            if (exp_q.size() == 0) begin
              errors++; checks++;
              $display("FAIL unexpected_vector actual=%h required=none", out_data);
            end else begin
              mon_e = exp_q.pop_front();
              check_vec("out_data", out_data, mon_e.d);
              done_due = mon_e.last;
            end
          end else begin
            held_valid = 1'b1;
            held_data  = out_data;
          end
        end else begin
          held_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_len = '0; cfg_num = '0; cfg_relu = 1'b0;
    #12;
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_vec("rst_out_data", out_data, '0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    @(posedge clk); #1; reset = 1'b1;

    // plain accumulation
    beat_q = '{all_lanes(100), all_lanes(-20), all_lanes(5)};
    run_job(3, 1, 1'b0, 1'b0);

    // ReLU on output only
    beat_q = '{'0, '0};
    beat_q[0][0 +: BW] = -16'sd10; beat_q[1][0 +: BW] = -16'sd5;
    beat_q[0][BW +: BW] = 16'sd7;  beat_q[1][BW +: BW] = 16'sd1;
    run_job(2, 1, 1'b1, 1'b0);

    // per-lane saturation both ways, other lanes carry small values
    beat_q = '{all_lanes(3), all_lanes(1)};
    beat_q[0][0 +: BW] = 16'sd30000;  beat_q[1][0 +: BW] = 16'sd30000;
    beat_q[0][BW +: BW] = -16'sd30000; beat_q[1][BW +: BW] = -16'sd30000;
    run_job(2, 1, 1'b0, 1'b0);

    // back-pressure on the 2nd of three vectors
    stall_ord = vec_ord + 2;
    beat_q = '{all_lanes(11), all_lanes(-22), all_lanes(33)};
    run_job(1, 3, 1'b0, 1'b0);

    // abort mid-job by reset, then a fresh job must not see stale sums
    do_start(4, 1, 1'b0);
    send_beat(all_lanes(7), 1'b0);
    #2; reset = 1'b0; in_valid = 1'b0; #1;
    check_bit("abort_in_ready", in_ready, 1'b0);
    check_bit("abort_out_valid", out_valid, 1'b0);
    check_vec("abort_out_data", out_data, '0);
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    beat_q = '{all_lanes(9)};
    run_job(1, 1, 1'b0, 1'b0);

    // start pulse and held in_valid during DRAIN must be ignored
    stall_ord = vec_ord + 1;
    beat_q = '{all_lanes(1000), all_lanes(-3), all_lanes(50), all_lanes(50)};
    model_job(2, 2, 1'b0);
    do_start(2, 2, 1'b0);
    fork
      begin
        foreach (beat_q[i]) send_beat(beat_q[i], 1'b0);
        in_valid = 1'b0;
      end
      begin
        int t = 0;
        while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
        start = 1'b1; cfg_len = 6'd5; cfg_num = 6'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    beat_q.delete();
    wait_idle();

    // randomized jobs, including zero configs and heavy saturation
    rand_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      int len = $urandom_range(0, 5);
      int num = $urandom_range(0, 3);
      int nb  = ((len == 0) ? 1 : len) * ((num == 0) ? 1 : num);
      for (int b = 0; b < nb; b++) begin
        logic [W-1:0] d;
        for (int k = 0; k < COL; k++) begin
          logic [31:0] rv = $urandom();
          if (rv[31:30] == 2'b00) d[k*BW +: BW] = 16'(int'($urandom_range(0, 400)) - 200);
          else d[k*BW +: BW] = rv[BW-1:0];
        end
        beat_q.push_back(d);
      end
      run_job(len, num, 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
